// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: upstream immediate/mode offer and downstream
// extended-result delivery, plus the queue occupancy.
interface ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err, count
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err, count
  );
endinterface

// File: rtl/ext_pipe.sv
// Buffered immediate extender: extends at the input, queues {err, data} in a
// DEPTH-entry FIFO and presents results in order on a valid/ready output.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  ext_pipe_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef logic [OUT_W:0] entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic          in_ready, out_valid;
  entry_t        in_entry, head;

  // Returns {err, data}; illegal modes produce a clean zero so nothing stale leaks.
  function automatic entry_t extend(input logic [IN_W-1:0] imm, input logic [2:0] mode);
    logic signed [OUT_W-1:0] sx;
    logic        [OUT_W-1:0] zx;
    entry_t                  r;
    sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    zx = {{(OUT_W-IN_W){1'b0}}, imm};
    case (mode)
      3'b000:  r = {1'b0, zx};
      3'b001:  r = {1'b0, sx};
      3'b010:  r = {1'b0, imm, {(OUT_W-IN_W){1'b0}}};
      3'b011:  r = {1'b0, sx <<< 2};
      3'b100:  r = {1'b0, zx << 2};
      default: r = {1'b1, {OUT_W{1'b0}}};
    endcase
    return r;
  endfunction

  assign in_entry  = extend(bus.in_imm, bus.in_mode);
  assign in_ready  = (count_q < FULL_CNT) && !flush;
  assign out_valid = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    push     = bus.in_valid && in_ready;
    pop      = out_valid && bus.out_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // flush wins over any simultaneous push or pop
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? head[OUT_W-1:0] : '0;
  assign bus.out_err   = out_valid ? head[OUT_W] : 1'b0;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: queue-based reference checked every cycle plus
// hand-computed literal checkpoints.
module tb_ext_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension done with integer arithmetic, truncated to OUT_W.
  function automatic logic [OUT_W:0] ref_ext(input logic [IN_W-1:0] imm, input logic [2:0] mode);
    longint zv, sv, v;
    logic [OUT_W-1:0] r;
    zv = longint'(imm);
    sv = (zv >= (64'sd1 << (IN_W-1))) ? zv - (64'sd1 << IN_W) : zv;
    case (mode)
      3'd0: v = zv;
      3'd1: v = sv;
      3'd2: v = zv * (64'sd1 << (OUT_W-IN_W));
      3'd3: v = sv * 4;
      3'd4: v = zv * 4;
      default: return {1'b1, {OUT_W{1'b0}}};
    endcase
    r = v[OUT_W-1:0];
    return {1'b0, r};
  endfunction

  logic [OUT_W:0] mq[$];

  always @(posedge clk or negedge reset) begin : model
    bit acc;
    if (!reset) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = bus.in_valid && (mq.size() < DEPTH);
      if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
      if (acc) mq.push_back(ref_ext(bus.in_imm, bus.in_mode));
    end
  end

  always @(negedge clk) begin : compare
    logic [OUT_W:0] hd;
    if (reset === 1'b1) begin
      hd = (mq.size() > 0) ? mq[0] : '0;
      chk("count",     64'(bus.count),     64'(mq.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      chk("out_data",  64'(bus.out_data),  64'(hd[OUT_W-1:0]));
      chk("out_err",   64'(bus.out_err),   64'(hd[OUT_W]));
      chk("in_ready",  64'(bus.in_ready),  64'((mq.size() < DEPTH) && !flush));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [IN_W-1:0] imm, input logic [2:0] mode);
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
  endtask

  logic [OUT_W-1:0] sweep_exp [4];

  initial begin
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;

    chk("model_s",   64'(ref_ext(16'h8000, 3'b001)), 64'h0_FFFF8000);
    chk("model_lui", 64'(ref_ext(16'h1234, 3'b010)), 64'h0_12340000);
    chk("model_br",  64'(ref_ext(16'hFFFF, 3'b011)), 64'h0_FFFFFFFC);
    chk("model_j",   64'(ref_ext(16'hFFFF, 3'b100)), 64'h0_0003FFFC);
    chk("model_ill", 64'(ref_ext(16'hABCD, 3'b110)), 64'h1_00000000);

    #2;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    step();
    step();
    reset = 1'b1;

    // sign extension, single item
    offer(16'h8000, 3'b001);
    step();
    bus.in_valid = 1'b0;
    chk("sx_valid", 64'(bus.out_valid), 64'd1);
    chk("sx_data",  64'(bus.out_data),  64'hFFFF8000);
    chk("sx_err",   64'(bus.out_err),   64'd0);
    chk("sx_count", 64'(bus.count),     64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("sx_pop_count", 64'(bus.count),    64'd0);
    chk("sx_pop_data",  64'(bus.out_data), 64'd0);

    // mode sweep streaming through
    sweep_exp[0] = 32'h00001234;
    sweep_exp[1] = 32'h12340000;
    sweep_exp[2] = 32'hFFFFFFFC;
    sweep_exp[3] = 32'h0003FFFC;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: offer(16'h1234, 3'b000);
        1: offer(16'h1234, 3'b010);
        2: offer(16'hFFFF, 3'b011);
        default: offer(16'hFFFF, 3'b100);
      endcase
      step();
      chk("sweep_data", 64'(bus.out_data), 64'(sweep_exp[i]));
      chk("sweep_count", 64'(bus.count), 64'd1);
    end
    bus.in_valid = 1'b0;
    step();

    // illegal modes then a legal item
    for (int m = 5; m < 8; m++) begin
      offer(16'hABCD, 3'(m));
      step();
      chk("ill_data", 64'(bus.out_data), 64'd0);
      chk("ill_err",  64'(bus.out_err),  64'd1);
    end
    offer(16'h1234, 3'b000);
    step();
    chk("legal_err",  64'(bus.out_err),  64'd0);
    chk("legal_data", 64'(bus.out_data), 64'h00001234);
    bus.in_valid = 1'b0;
    step();

    // fill with backpressure, then drain
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      offer(IN_W'(k), 3'b000);
      step();
    end
    chk("full_count", 64'(bus.count),    64'd4);
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    offer(16'd5, 3'b000);
    step();
    step();
    chk("held_count", 64'(bus.count), 64'd4);
    bus.out_ready = 1'b1;
    step();
    chk("drain1_data",  64'(bus.out_data), 64'd2);
    chk("drain1_count", 64'(bus.count),    64'd3);
    chk("drain1_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("drain2_data",  64'(bus.out_data), 64'd3);
    chk("drain2_count", 64'(bus.count),    64'd3);
    step();
    chk("drain3_data", 64'(bus.out_data), 64'd4);
    step();
    chk("drain4_data", 64'(bus.out_data), 64'd5);
    chk("drain4_count", 64'(bus.count),   64'd1);
    step();
    chk("drain_empty", 64'(bus.count), 64'd0);

    // continuous push+pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      offer(IN_W'(100 + i), 3'b000);
      step();
      chk("wrap_data",  64'(bus.out_data), 64'(100 + i));
      chk("wrap_count", 64'(bus.count),    64'd1);
    end
    bus.in_valid = 1'b0;
    step();

    // flush with an item on offer
    bus.out_ready = 1'b0;
    for (int k = 7; k <= 9; k++) begin
      offer(IN_W'(k), 3'b000);
      step();
    end
    chk("pre_flush_count", 64'(bus.count), 64'd3);
    offer(16'h0055, 3'b000);
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(bus.in_ready), 64'd0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", 64'(bus.count),     64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("flush_absent", 64'(bus.out_valid), 64'd0);

    // async reset between edges
    offer(16'h0066, 3'b000);
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_count", 64'(bus.count), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_count", 64'(bus.count),     64'd0);
    chk("arst_data",  64'(bus.out_data),  64'd0);
    chk("arst_ready", 64'(bus.in_ready),  64'd1);
    step();
    reset = 1'b1;
    offer(16'h0077, 3'b001);
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_count", 64'(bus.count),    64'd1);
    chk("post_rst_data",  64'(bus.out_data), 64'h00000077);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, buffered immediate-extension stage for the pipelined MIPS datapath. It accepts raw immediates with an extension mode through a valid/ready handshake and computes the extended value at the input. Results queue in an internal FIFO of configurable depth and are presented in order on a valid/ready output. It replaces the purely combinational extender wherever decode and execute are decoupled, and it adds branch/jump offset modes, illegal-mode flagging and pipeline flush.

## Interface
- IN_W, 16, immediate width; 2 ≤ IN_W, IN_W + 2 ≤ OUT_W
- OUT_W, 32, extended result width
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately on assertion, independent of clk
- flush  input  1  synchronous queue clear (exception/branch squash)
- in_valid  input  1  input item present
- in_ready  output  1  stage can accept an item
- in_imm  input  IN_W  raw immediate
- in_mode  input  3  extension mode
- out_valid  output  1  head item present
- out_ready  input  1  consumer takes head item
- out_data  output  OUT_W  extended value of head item
- out_err  output  1  head item had an illegal mode
- count  output  $clog2(DEPTH)+1  number of queued items

## Operation
- Mode encoding (s = sign-extend in_imm to OUT_W; z = zero-extend in_imm to OUT_W):
  - 000: z
  - 001: s
  - 010: load-upper, in_imm << (OUT_W-IN_W), low bits zero
  - 011: s << 2, branch offset; top bits shifted out are discarded
  - 100: z << 2, jump-index style
  - 101, 110, 111: illegal; data = 0, err = 1. The stage never holds a stale value for an illegal mode.
- The extension is computed combinationally from in_imm and in_mode. The {data, err} pair is written into the FIFO on accept.
- Accept (push) occurs when in_valid && in_ready. in_ready = (count < DEPTH) && !flush. in_ready does not depend on out_ready, so there is no pass-through when the FIFO is full.
- Pop occurs when out_valid && out_ready. out_valid = (count != 0).
- out_data and out_err always reflect the FIFO head. When out_valid = 0 they are driven to 0.
- Read and write pointers wrap modulo DEPTH. Strict FIFO ordering is maintained.
- Count updates:
  - Push and pop in the same cycle: count unchanged. Both pointers advance.
  - Push only: count + 1.
  - Pop only: count − 1.
- flush has priority over push and pop. When flush is high at an edge:
  - both pointers and count go to 0;
  - any item offered in the same cycle is dropped;
  - no pop is reported.
- Changing in_imm or in_mode while in_valid is high and in_ready is low is permitted. Only the values present at the accepting edge are stored.

## Timing
- Reset values: count = 0, out_valid = 0, out_data = 0, out_err = 0, in_ready = 1, pointers = 0. FIFO contents are don't-care.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronous), with no edge required. Release is synchronised by the first clk edge after deassertion, and the first accept can occur at that edge.
- Latency: an item accepted at edge k appears on out_valid/out_data after edge k, i.e. in cycle k+1. It can be popped at edge k+1.
- Throughput: one item per cycle sustained whenever out_ready = 1 and 0 < count < DEPTH.
- Full: count = DEPTH gives in_ready = 0. in_ready returns to 1 the cycle after the first pop.
- Empty: a pop is impossible. out_ready with out_valid = 0 has no effect.

## Test plan
- Sign extend: reset, push in_imm=16'h8000, mode=001 → next cycle out_valid=1, out_data=32'hFFFF8000, out_err=0, count=1; pop → count=0, out_data=0.
- Mode sweep (out_ready=1):
  - 16'h1234 mode 000 → 32'h00001234
  - 16'h1234 mode 010 → 32'h12340000
  - 16'hFFFF mode 011 → 32'hFFFFFFFC
  - 16'hFFFF mode 100 → 32'h0003FFFC
  - Results appear in push order, one per cycle.
- Illegal modes: push 16'hABCD with each of modes 101/110/111 → out_data=0, out_err=1. A following legal item has out_err=0.
- Full/backpressure: out_ready=0, offer 5 items (values 1..5, mode 000) → in_ready=0 after the 4th accept, count=4, item 5 held. Raise out_ready → outputs 1,2,3,4,5 in order, and item 5 is accepted the cycle after the first pop.
- Wrap-around: continuous push+pop for 10 cycles with incrementing values → count stays 1 and every value is delivered exactly once in order across pointer wrap.
- Flush/reset: with count=3 and in_valid=1, pulse flush → count=0 and out_valid=0 next cycle, offered item absent. Then push, and assert reset between edges → out_valid=0 and count=0 before the next edge.
